// File: rtl/draw_pkg.sv
// Shared draw-engine types and defaults for the pixel-to-tile resolver.
package draw_pkg;

  localparam int TILE_W_LOG2_DEF = 5;
  localparam int TILE_BITS_DEF   = 4;
  localparam int COORD_BITS      = 10;

  typedef logic [COORD_BITS-1:0]    coord_t;
  typedef logic [TILE_BITS_DEF-1:0] tile_t;

  // Width of a region index; a single region still needs one bit.
  function automatic int reg_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/region_match.sv
// One region's bounds test and origin-relative offset (purely combinational).
module region_match
  import draw_pkg::*;
#(
  parameter int         TILE_W_LOG2 = TILE_W_LOG2_DEF,
  parameter coord_t     ORG_X       = '0,
  parameter coord_t     ORG_Y       = '0,
  parameter logic [3:0] TW          = 4'd1,
  parameter logic [3:0] TH          = 4'd1
) (
  input  coord_t i_x,
  input  coord_t i_y,
  output logic   o_hit,
  output coord_t o_pos_x,
  output coord_t o_pos_y
);

  // Exclusive right/bottom limits, wide enough that origin + extent never wraps.
  localparam logic [11:0] LIM_X = 12'(ORG_X) + (12'(TW) << TILE_W_LOG2);
  localparam logic [11:0] LIM_Y = 12'(ORG_Y) + (12'(TH) << TILE_W_LOG2);

  logic w_in_x;
  logic w_in_y;

  assign w_in_x  = (i_x >= ORG_X) && ({2'b00, i_x} < LIM_X);
  assign w_in_y  = (i_y >= ORG_Y) && ({2'b00, i_y} < LIM_Y);
  assign o_hit   = w_in_x && w_in_y;
  assign o_pos_x = i_x - ORG_X;
  assign o_pos_y = i_y - ORG_Y;

endmodule

// File: rtl/tile_pos_pipe.sv
// Two-stage raster-to-tile resolver: S1 tests every region in parallel,
// S2 picks the lowest-index hit and derives tile coordinate, index and offset.
module tile_pos_pipe
  import draw_pkg::*;
#(
  parameter int                          NUM_REGIONS = 2,
  parameter int                          TILE_W_LOG2 = TILE_W_LOG2_DEF,
  parameter int                          TILE_BITS   = TILE_BITS_DEF,
  parameter int                          IDX_BITS    = 8,
  parameter logic [NUM_REGIONS-1:0][9:0] REGION_X    = {10'd32, 10'd254},
  parameter logic [NUM_REGIONS-1:0][9:0] REGION_Y    = {10'd32, 10'd32},
  parameter logic [NUM_REGIONS-1:0][3:0] REGION_TW   = {4'd6, 4'd11},
  parameter logic [NUM_REGIONS-1:0][3:0] REGION_TH   = {4'd11, 4'd11},
  localparam int                         REG_BITS    = reg_bits(NUM_REGIONS)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  coord_t                   DrawX,
  input  coord_t                   DrawY,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     hit,
  output logic [REG_BITS-1:0]      region,
  output logic [TILE_BITS-1:0]     tileX,
  output logic [TILE_BITS-1:0]     tileY,
  output logic [IDX_BITS-1:0]      tileIdx,
  output logic [2*TILE_W_LOG2-1:0] relPos
);

  logic                     w_s1_adv;
  logic                     w_s2_adv;
  logic [NUM_REGIONS-1:0]   w_hit;
  coord_t                   w_pos_x [NUM_REGIONS];
  coord_t                   w_pos_y [NUM_REGIONS];

  logic                     r_s1_valid;
  logic [NUM_REGIONS-1:0]   r_s1_hit;
  coord_t                   r_s1_pos_x [NUM_REGIONS];
  coord_t                   r_s1_pos_y [NUM_REGIONS];

  logic                     r_s2_valid;
  logic                     r_hit;
  logic [REG_BITS-1:0]      r_region;
  logic [TILE_BITS-1:0]     r_tile_x;
  logic [TILE_BITS-1:0]     r_tile_y;
  logic [IDX_BITS-1:0]      r_tile_idx;
  logic [2*TILE_W_LOG2-1:0] r_rel_pos;

  logic                     w_sel_hit;
  logic [REG_BITS-1:0]      w_sel_region;
  coord_t                   w_sel_x;
  coord_t                   w_sel_y;
  logic [3:0]               w_sel_tw;
  coord_t                   w_shift_x;
  coord_t                   w_shift_y;
  logic [TILE_BITS-1:0]     w_tile_x;
  logic [TILE_BITS-1:0]     w_tile_y;
  logic [31:0]              w_idx_full;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      region_match #(
        .TILE_W_LOG2 (TILE_W_LOG2),
        .ORG_X       (REGION_X[gi]),
        .ORG_Y       (REGION_Y[gi]),
        .TW          (REGION_TW[gi]),
        .TH          (REGION_TH[gi])
      ) u_match (
        .i_x     (DrawX),
        .i_y     (DrawY),
        .o_hit   (w_hit[gi]),
        .o_pos_x (w_pos_x[gi]),
        .o_pos_y (w_pos_y[gi])
      );
    end
  endgenerate

  // S1 payload needs no reset: it is only consumed when r_s1_valid is set.
  always_ff @(posedge Clk) begin
    if (w_s1_adv) begin
      r_s1_hit <= w_hit;
      for (int r = 0; r < NUM_REGIONS; r++) begin
        r_s1_pos_x[r] <= w_pos_x[r];
        r_s1_pos_y[r] <= w_pos_y[r];
      end
    end
  end

  // Walk high to low so the lowest-index hitting region overrides the rest.
  always_comb begin
    w_sel_hit    = 1'b0;
    w_sel_region = '0;
    w_sel_x      = '0;
    w_sel_y      = '0;
    w_sel_tw     = '0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if (r_s1_hit[r]) begin
        w_sel_hit    = 1'b1;
        w_sel_region = REG_BITS'(r);
        w_sel_x      = r_s1_pos_x[r];
        w_sel_y      = r_s1_pos_y[r];
        w_sel_tw     = REGION_TW[r];
      end
    end
  end

  assign w_shift_x  = w_sel_x >> TILE_W_LOG2;
  assign w_shift_y  = w_sel_y >> TILE_W_LOG2;
  assign w_tile_x   = w_shift_x[TILE_BITS-1:0];
  assign w_tile_y   = w_shift_y[TILE_BITS-1:0];
  assign w_idx_full = 32'(w_tile_y) * 32'(w_sel_tw) + 32'(w_tile_x);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= in_valid;
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
    end
  end

  // A miss leaves every select at zero, so all result fields come out zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hit      <= 1'b0;
      r_region   <= '0;
      r_tile_x   <= '0;
      r_tile_y   <= '0;
      r_tile_idx <= '0;
      r_rel_pos  <= '0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_hit      <= w_sel_hit;
      r_region   <= w_sel_region;
      r_tile_x   <= w_tile_x;
      r_tile_y   <= w_tile_y;
      r_tile_idx <= w_idx_full[IDX_BITS-1:0];
      r_rel_pos  <= {w_sel_y[TILE_W_LOG2-1:0], w_sel_x[TILE_W_LOG2-1:0]};
    end
  end

  assign out_valid = r_s2_valid;
  assign hit       = r_hit;
  assign region    = r_region;
  assign tileX     = r_tile_x;
  assign tileY     = r_tile_y;
  assign tileIdx   = r_tile_idx;
  assign relPos    = r_rel_pos;

endmodule

// File: tb/tb_tile_pos_pipe.sv
// Directed bench for tile_pos_pipe: default map/panel layout plus an overlapping-region variant.
module tb_tile_pos_pipe;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, hit;
  logic [0:0] region;
  logic [3:0] tileX, tileY;
  logic [7:0] tileIdx;
  logic [9:0] relPos;

  logic       ov_in_ready, ov_out_valid, ov_hit;
  logic [0:0] ov_region;
  logic [3:0] ov_tileX, ov_tileY;
  logic [7:0] ov_tileIdx;
  logic [9:0] ov_relPos;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  tile_pos_pipe dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .hit(hit), .region(region), .tileX(tileX), .tileY(tileY), .tileIdx(tileIdx), .relPos(relPos)
  );

  tile_pos_pipe #(
    .REGION_X({10'd32, 10'd32}), .REGION_Y({10'd32, 10'd32}),
    .REGION_TW({4'd6, 4'd11}), .REGION_TH({4'd11, 4'd11})
  ) dut_ov (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .in_valid(in_valid), .in_ready(ov_in_ready), .out_valid(ov_out_valid), .out_ready(out_ready),
    .hit(ov_hit), .region(ov_region), .tileX(ov_tileX), .tileY(ov_tileY), .tileIdx(ov_tileIdx),
    .relPos(ov_relPos)
  );

  // Presents one coordinate to an idle pipe and waits (bounded) for its result.
  task automatic run_one(input logic [9:0] x, input logic [9:0] y, output int lat);
    DrawX = x; DrawY = y; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge Clk); #1;
      lat++;
    end
    if (!out_valid) lat = 99;
    $display("txn x=%0d y=%0d hit=%0b region=%0d tile=(%0d,%0d) idx=%0d rel=%0d lat=%0d",
             x, y, hit, region, tileX, tileY, tileIdx, relPos, lat);
  endtask

  task automatic drain;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if ({hit, region, tileX, tileY, tileIdx, relPos} !== '0) begin
      failures++; $display("FAIL reset_fields got=%h exp=0", {hit, region, tileX, tileY, tileIdx, relPos}); end
    #10 Reset = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_vectors;
    logic [9:0] vx [10] = '{10'd254, 10'd300, 10'd253, 10'd605, 10'd606, 10'd40, 10'd10, 10'd40, 10'd223, 10'd254};
    logic [9:0] vy [10] = '{10'd32, 10'd70, 10'd32, 10'd383, 10'd32, 10'd33, 10'd10, 10'd384, 10'd383, 10'd384};
    logic       eh [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [0:0] er [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] etx[10] = '{4'd0, 4'd1, 4'd0, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0};
    logic [3:0] ety[10] = '{4'd0, 4'd1, 4'd0, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0, 4'd10, 4'd0};
    logic [7:0] ei [10] = '{8'd0, 8'd12, 8'd0, 8'd120, 8'd0, 8'd0, 8'd0, 8'd0, 8'd65, 8'd0};
    logic [9:0] ep [10] = '{10'd0, 10'd206, 10'd0, 10'd1023, 10'd0, 10'd40, 10'd0, 10'd0, 10'd1023, 10'd0};
    int lat;
    drain();
    for (int i = 0; i < 10; i++) begin
      run_one(vx[i], vy[i], lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=2", i, lat); end
      checks++; if (hit !== eh[i]) begin failures++; $display("FAIL vec%0d_hit got=%0b exp=%0b", i, hit, eh[i]); end
      checks++; if (region !== er[i]) begin failures++; $display("FAIL vec%0d_region got=%0d exp=%0d", i, region, er[i]); end
      checks++; if (tileX !== etx[i]) begin failures++; $display("FAIL vec%0d_tileX got=%0d exp=%0d", i, tileX, etx[i]); end
      checks++; if (tileY !== ety[i]) begin failures++; $display("FAIL vec%0d_tileY got=%0d exp=%0d", i, tileY, ety[i]); end
      checks++; if (tileIdx !== ei[i]) begin failures++; $display("FAIL vec%0d_tileIdx got=%0d exp=%0d", i, tileIdx, ei[i]); end
      checks++; if (relPos !== ep[i]) begin failures++; $display("FAIL vec%0d_relPos got=%0d exp=%0d", i, relPos, ep[i]); end
    end
  endtask

  task automatic test_overlap;
    int lat;
    drain();
    run_one(10'd100, 10'd100, lat);
    checks++; if (region !== 1'b1 || tileIdx !== 8'd14) begin failures++;
      $display("FAIL ovl_default got=r%0d/i%0d exp=r1/i14", region, tileIdx); end
    checks++; if (ov_out_valid !== 1'b1 || ov_hit !== 1'b1) begin failures++;
      $display("FAIL ovl_valid_hit got=%0b%0b exp=11", ov_out_valid, ov_hit); end
    checks++; if (ov_region !== 1'b0) begin failures++; $display("FAIL ovl_region got=%0d exp=0", ov_region); end
    checks++; if (ov_tileIdx !== 8'd24) begin failures++; $display("FAIL ovl_tileIdx got=%0d exp=24", ov_tileIdx); end
    checks++; if (ov_relPos !== 10'd132) begin failures++; $display("FAIL ovl_relPos got=%0d exp=132", ov_relPos); end
    drain();
    run_one(10'd40, 10'd33, lat);
    checks++; if (ov_region !== 1'b0 || ov_relPos !== 10'd40 || ov_tileIdx !== 8'd0) begin failures++;
      $display("FAIL ovl_corner got=r%0d/i%0d/p%0d exp=r0/i0/p40", ov_region, ov_tileIdx, ov_relPos); end
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int recv = 0;
    logic exp_ir, exp_ov;
    drain();
    for (int c = 0; c < 13; c++) begin
      out_ready = !(c >= 3 && c < 6);
      if (sent < 5) begin
        in_valid = 1'b1; DrawX = 10'(254 + 32 * sent); DrawY = 10'd32;
      end else begin
        in_valid = 1'b0;
      end
      #4;
      exp_ir = !(c >= 3 && c < 6);
      exp_ov = (c >= 2 && c <= 9);
      checks++; if (in_ready !== exp_ir) begin failures++; $display("FAIL b2b_in_ready c%0d got=%0b exp=%0b", c, in_ready, exp_ir); end
      checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL b2b_out_valid c%0d got=%0b exp=%0b", c, out_valid, exp_ov); end
      if (out_valid && recv < 5) begin
        checks++; if (tileIdx !== 8'(recv) || tileX !== 4'(recv)) begin failures++;
          $display("FAIL b2b_order c%0d got=%0d/%0d exp=%0d", c, tileIdx, tileX, recv); end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        $display("txn b2b c=%0d idx=%0d tileX=%0d", c, tileIdx, tileX);
        recv++;
      end
      @(posedge Clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (recv !== 5 || sent !== 5) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=5/5", sent, recv); end
  endtask

  task automatic test_reset_midstream;
    int lat;
    drain();
    out_ready = 1'b0; in_valid = 1'b1; DrawX = 10'd300; DrawY = 10'd70;
    @(posedge Clk); #1;
    DrawX = 10'd605; DrawY = 10'd383;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || tileIdx !== 8'd12 || in_ready !== 1'b0) begin failures++;
      $display("FAIL rst_prefill got=v%0b/i%0d/r%0b exp=v1/i12/r0", out_valid, tileIdx, in_ready); end
    #2 Reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_out_valid got=%0b exp=0", out_valid); end
    checks++; if ({hit, region, tileX, tileY, tileIdx, relPos} !== '0) begin failures++;
      $display("FAIL rst_async_fields got=%h exp=0", {hit, region, tileX, tileY, tileIdx, relPos}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_in_ready got=%0b exp=1", in_ready); end
    #1 Reset = 1'b0;
    @(posedge Clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_no_ghost got=%0b exp=0", out_valid); end
    run_one(10'd605, 10'd383, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rst_post_latency got=%0d exp=2", lat); end
    checks++; if (tileIdx !== 8'd120 || relPos !== 10'd1023) begin failures++;
      $display("FAIL rst_post_result got=i%0d/p%0d exp=i120/p1023", tileIdx, relPos); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_overlap();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
